// File: rtl/amo_unit.sv
// RISC-V "A" extension execution unit: LR, SC and the nine AMOs as a read-modify-write
// sequencer between the issue stage and the data-memory port, with an LR/SC reservation.
module amo_unit #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 6,
  parameter int RES_LSB = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_funct5,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_data,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_we,
  output logic             mem_req_size,
  output logic [XLEN-1:0]  mem_req_addr,
  output logic [XLEN-1:0]  mem_req_wdata,
  input  logic             mem_rsp_valid,
  input  logic [XLEN-1:0]  mem_rsp_rdata,
  input  logic             snoop_valid,
  input  logic [XLEN-1:0]  snoop_addr
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  localparam int GW = XLEN - RES_LSB;

  logic [2:0]       state;
  logic [4:0]       op_q;
  logic             is_d_q;
  logic [XLEN-1:0]  addr_q;
  logic [XLEN-1:0]  rs2_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  wdata_q;
  logic [XLEN-1:0]  resp_data_q;
  logic             resp_err_q;
  logic             res_valid;
  logic [GW-1:0]    res_gran;
  logic             lr_cancel;

  logic             accept;
  logic             op_known;
  logic             width_ok;
  logic             req_is_d;
  logic             misaligned;
  logic             req_err;
  logic [GW-1:0]    req_gran;
  logic [GW-1:0]    addr_gran;
  logic [GW-1:0]    snoop_gran;
  logic             snoop_res_hit;
  logic             snoop_req_hit;
  logic             snoop_lr_hit;
  logic             sc_ok;
  logic [XLEN-1:0]  opa;
  logic [XLEN-1:0]  opb;
  logic [XLEN-1:0]  alu;
  logic [XLEN-1:0]  wr_val;
  logic             unused_snoop_lsbs;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  assign accept            = req_valid && req_ready;
  assign req_gran          = req_addr[XLEN-1:RES_LSB];
  assign addr_gran         = addr_q[XLEN-1:RES_LSB];
  assign snoop_gran        = snoop_addr[XLEN-1:RES_LSB];
  assign unused_snoop_lsbs = ^snoop_addr[RES_LSB-1:0];

  assign snoop_res_hit = snoop_valid && res_valid && (snoop_gran == res_gran);
  assign snoop_req_hit = snoop_valid && (snoop_gran == req_gran);
  assign snoop_lr_hit  = snoop_valid && (snoop_gran == addr_gran);
  assign sc_ok         = res_valid && (res_gran == req_gran) && !snoop_req_hit;

  always_comb begin
    case (req_funct5)
      F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
      F_MIN, F_MAX, F_MINU, F_MAXU: op_known = 1'b1;
      default:                       op_known = 1'b0;
    endcase
    req_is_d   = (req_funct3 == 3'b011);
    width_ok   = (req_funct3 == 3'b010) || (req_is_d && (XLEN == 64));
    misaligned = req_is_d ? (req_addr[2:0] != 3'b000) : (req_addr[1:0] != 2'b00);
    req_err    = !op_known || !width_ok || misaligned;
  end

  // Word ops run on sign-extended operands: low 32 bits of every result are then exact,
  // and unsigned ordering is preserved by sign extension.
  always_comb begin
    opa = is_d_q ? mem_rsp_rdata : sext32(mem_rsp_rdata[31:0]);
    opb = is_d_q ? rs2_q : sext32(rs2_q[31:0]);
    case (op_q)
      F_SWAP:  alu = opb;
      F_ADD:   alu = opa + opb;
      F_XOR:   alu = opa ^ opb;
      F_AND:   alu = opa & opb;
      F_OR:    alu = opa | opb;
      F_MIN:   alu = ($signed(opa) < $signed(opb)) ? opa : opb;
      F_MAX:   alu = ($signed(opa) > $signed(opb)) ? opa : opb;
      F_MINU:  alu = (opa < opb) ? opa : opb;
      F_MAXU:  alu = (opa > opb) ? opa : opb;
      default: alu = opb;
    endcase
    wr_val = is_d_q ? alu : zext32(alu[31:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      is_d_q      <= 1'b0;
      addr_q      <= '0;
      rs2_q       <= '0;
      tag_q       <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      res_valid   <= 1'b0;
      res_gran    <= '0;
      lr_cancel   <= 1'b0;
    end else begin
      if (snoop_res_hit) res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q       <= req_funct5;
            is_d_q     <= req_is_d;
            addr_q     <= req_addr;
            rs2_q      <= req_data;
            tag_q      <= req_tag;
            lr_cancel  <= snoop_req_hit;
            resp_err_q <= 1'b0;
            if (req_err) begin
              resp_err_q  <= 1'b1;
              resp_data_q <= '0;
              state       <= S_RESP;
            end else if (req_funct5 == F_SC) begin
              res_valid <= 1'b0;
              if (sc_ok) begin
                wdata_q     <= req_is_d ? req_data : zext32(req_data[31:0]);
                resp_data_q <= '0;
                state       <= S_WR;
              end else begin
                resp_data_q <= XLEN'(1);
                state       <= S_RESP;
              end
            end else begin
              if (req_funct5 != F_LR && res_valid && res_gran == req_gran)
                res_valid <= 1'b0;
              state <= S_RD;
            end
          end
        end
        S_RD: begin
          if (snoop_lr_hit) lr_cancel <= 1'b1;
          if (mem_req_ready) state <= S_RD_WAIT;
        end
        // A snoop anywhere between accept and data return vetoes the LR reservation.
        S_RD_WAIT: begin
          if (snoop_lr_hit) lr_cancel <= 1'b1;
          if (mem_rsp_valid) begin
            resp_data_q <= opa;
            wdata_q     <= wr_val;
            if (op_q == F_LR) begin
              if (!lr_cancel && !snoop_lr_hit) begin
                res_valid <= 1'b1;
                res_gran  <= addr_gran;
              end
              state <= S_RESP;
            end else begin
              state <= S_WR;
            end
          end
        end
        S_WR: begin
          if (mem_req_ready) state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (state == S_IDLE);
  assign resp_valid    = (state == S_RESP);
  assign resp_data     = resp_data_q;
  assign resp_tag      = tag_q;
  assign resp_err      = resp_err_q;
  assign mem_req_valid = (state == S_RD) || (state == S_WR);
  assign mem_req_we    = (state == S_WR);
  assign mem_req_size  = is_d_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;

endmodule

// File: tb/tb_amo_unit.sv
// Directed bench for amo_unit: one XLEN=32 and one XLEN=64 instance sharing a word memory model.
module tb_amo_unit;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;
  localparam logic [2:0] W3 = 3'b010;
  localparam logic [2:0] D3 = 3'b011;

  logic clk = 1'b0;
  logic reset, resp_ready, snoop_v, rv32, rv64, mrdy32, mrdy64, model_clr;
  logic [4:0] f5;
  logic [2:0] f3;
  logic [63:0] addr, data, snoop_a;
  logic [5:0] tag;

  logic r32_ready, r32_valid, r32_err, m32_valid, m32_we, m32_size;
  logic [31:0] r32_data, m32_addr, m32_wdata;
  logic [5:0] r32_tag;
  logic rsp_v32;
  logic [31:0] rsp_d32;

  logic r64_ready, r64_valid, r64_err, m64_valid, m64_we, m64_size;
  logic [63:0] r64_data, m64_addr, m64_wdata;
  logic [5:0] r64_tag;
  logic rsp_v64;
  logic [63:0] rsp_d64;

  logic [31:0] mem [0:1023];
  logic poke_en;
  logic [9:0] poke_idx;
  logic [31:0] poke_val;
  int n_rd32, n_wr32, n_rd64, n_wr64;
  logic [31:0] last_waddr32, last_wdata32;
  logic [63:0] last_waddr64, last_wdata64;
  logic last_wsize64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  amo_unit #(.XLEN(32), .TAG_W(6), .RES_LSB(3)) u32 (
    .clk(clk), .reset(reset),
    .req_valid(rv32), .req_ready(r32_ready), .req_funct5(f5), .req_funct3(f3),
    .req_addr(addr[31:0]), .req_data(data[31:0]), .req_tag(tag),
    .resp_valid(r32_valid), .resp_ready(resp_ready), .resp_data(r32_data),
    .resp_tag(r32_tag), .resp_err(r32_err),
    .mem_req_valid(m32_valid), .mem_req_ready(mrdy32), .mem_req_we(m32_we),
    .mem_req_size(m32_size), .mem_req_addr(m32_addr), .mem_req_wdata(m32_wdata),
    .mem_rsp_valid(rsp_v32), .mem_rsp_rdata(rsp_d32),
    .snoop_valid(snoop_v), .snoop_addr(snoop_a[31:0])
  );

  amo_unit #(.XLEN(64), .TAG_W(6), .RES_LSB(3)) u64 (
    .clk(clk), .reset(reset),
    .req_valid(rv64), .req_ready(r64_ready), .req_funct5(f5), .req_funct3(f3),
    .req_addr(addr), .req_data(data), .req_tag(tag),
    .resp_valid(r64_valid), .resp_ready(resp_ready), .resp_data(r64_data),
    .resp_tag(r64_tag), .resp_err(r64_err),
    .mem_req_valid(m64_valid), .mem_req_ready(mrdy64), .mem_req_we(m64_we),
    .mem_req_size(m64_size), .mem_req_addr(m64_addr), .mem_req_wdata(m64_wdata),
    .mem_rsp_valid(rsp_v64), .mem_rsp_rdata(rsp_d64),
    .snoop_valid(snoop_v), .snoop_addr(snoop_a)
  );

  // Zero-wait memory: read data returns the cycle after the read handshake.
  always @(posedge clk) begin
    rsp_v32 <= 1'b0;
    rsp_v64 <= 1'b0;
    if (poke_en) mem[poke_idx] <= poke_val;
    if (model_clr) begin
      n_rd32 <= 0; n_wr32 <= 0; n_rd64 <= 0; n_wr64 <= 0;
    end else begin
      if (m32_valid && mrdy32) begin
        if (m32_we) begin
          mem[m32_addr[11:2]] <= m32_wdata;
          n_wr32       <= n_wr32 + 1;
          last_waddr32 <= m32_addr;
          last_wdata32 <= m32_wdata;
        end else begin
          rsp_v32 <= 1'b1;
          rsp_d32 <= mem[m32_addr[11:2]];
          n_rd32  <= n_rd32 + 1;
        end
      end
      if (m64_valid && mrdy64) begin
        if (m64_we) begin
          mem[m64_addr[11:2]] <= m64_wdata[31:0];
          if (m64_size) mem[m64_addr[11:2] + 10'd1] <= m64_wdata[63:32];
          n_wr64       <= n_wr64 + 1;
          last_waddr64 <= m64_addr;
          last_wdata64 <= m64_wdata;
          last_wsize64 <= m64_size;
        end else begin
          rsp_v64 <= 1'b1;
          rsp_d64 <= m64_size ? {mem[m64_addr[11:2] + 10'd1], mem[m64_addr[11:2]]}
                              : {32'h0, mem[m64_addr[11:2]]};
          n_rd64  <= n_rd64 + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", name, observed, expected);
    end
  endtask

  task automatic poke(input logic [63:0] a, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = a[11:2]; poke_val = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issues one request and waits (bounded) for its response; snoop_cyc selects the
  // cycle after accept (0 = accept cycle, -1 = none) in which snoop_at is broadcast.
  task automatic applyStimulus(input bit use64, input logic [4:0] fn5, input logic [2:0] fn3,
                               input logic [63:0] a, input logic [63:0] d, input logic [5:0] t,
                               input int snoop_cyc, input logic [63:0] snoop_at,
                               output logic [63:0] rd, output logic err,
                               output logic [5:0] rtag, output int lat);
    @(negedge clk);
    checkOutput("req_ready_idle", 64'(use64 ? r64_ready : r32_ready), 64'd1);
    f5 = fn5; f3 = fn3; addr = a; data = d; tag = t;
    if (use64) rv64 = 1'b1; else rv32 = 1'b1;
    snoop_a = snoop_at;
    snoop_v = (snoop_cyc == 0);
    @(negedge clk);
    rv32 = 1'b0; rv64 = 1'b0;
    lat = 1;
    snoop_v = (snoop_cyc == 1);
    while (!(use64 ? r64_valid : r32_valid) && lat < 40) begin
      @(negedge clk);
      lat++;
      snoop_v = (snoop_cyc == lat);
    end
    snoop_v = 1'b0;
    checkOutput("resp_seen", 64'(use64 ? r64_valid : r32_valid), 64'd1);
    rd   = use64 ? r64_data : {32'h0, r32_data};
    err  = use64 ? r64_err : r32_err;
    rtag = use64 ? r64_tag : r32_tag;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rd;
    logic err;
    logic [5:0] rt;
    int lat, rd0, wr0, w;

    reset = 1'b1; model_clr = 1'b1; resp_ready = 1'b1; snoop_v = 1'b0; snoop_a = '0;
    rv32 = 1'b0; rv64 = 1'b0; mrdy32 = 1'b1; mrdy64 = 1'b1; poke_en = 1'b0;
    poke_idx = '0; poke_val = '0; f5 = '0; f3 = '0; addr = '0; data = '0; tag = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", 64'(r64_ready), 64'd1);
    checkOutput("rst_resp_valid", 64'(r64_valid), 64'd0);
    checkOutput("rst_resp_err", 64'(r64_err), 64'd0);
    checkOutput("rst_resp_data", r64_data, 64'd0);
    checkOutput("rst_resp_tag", 64'(r64_tag), 64'd0);
    checkOutput("rst_mem_valid", 64'(m64_valid), 64'd0);
    checkOutput("rst_mem_we", 64'(m64_we), 64'd0);
    checkOutput("rst32_req_ready", 64'(r32_ready), 64'd1);
    checkOutput("rst32_mem_valid", 64'(m32_valid), 64'd0);
    reset = 1'b0; model_clr = 1'b0;

    // XLEN=32 AMOADD.W
    poke(64'h100, 32'd5);
    applyStimulus(1'b0, F_ADD, W3, 64'h100, 64'd7, 6'h03, -1, '0, rd, err, rt, lat);
    checkOutput("add32_rd", rd, 64'd5);
    checkOutput("add32_err", 64'(err), 64'd0);
    checkOutput("add32_tag", 64'(rt), 64'h03);
    checkOutput("add32_lat", 64'(lat), 64'd4);
    checkOutput("add32_reads", 64'(n_rd32), 64'd1);
    checkOutput("add32_writes", 64'(n_wr32), 64'd1);
    checkOutput("add32_waddr", 64'(last_waddr32), 64'h100);
    checkOutput("add32_wdata", 64'(last_wdata32), 64'd12);
    applyStimulus(1'b0, F_ADD, D3, 64'h100, 64'd7, 6'h04, -1, '0, rd, err, rt, lat);
    checkOutput("d_on_x32_err", 64'(err), 64'd1);
    checkOutput("d_on_x32_rd", rd, 64'd0);
    checkOutput("d_on_x32_nomem", 64'(n_rd32 + n_wr32), 64'd2);

    // XLEN=64 word MIN then doubleword MINU on the same location
    poke(64'h200, 32'h8000_0000);
    poke(64'h204, 32'hFFFF_FFFF);
    applyStimulus(1'b1, F_MIN, W3, 64'h200, 64'd1, 6'h10, -1, '0, rd, err, rt, lat);
    checkOutput("minw_rd", rd, 64'hFFFF_FFFF_8000_0000);
    checkOutput("minw_wdata", {32'h0, last_wdata64[31:0]}, 64'h8000_0000);
    checkOutput("minw_wsize", 64'(last_wsize64), 64'd0);
    checkOutput("minw_tag", 64'(rt), 64'h10);
    applyStimulus(1'b1, F_MINU, D3, 64'h200, 64'd1, 6'h11, -1, '0, rd, err, rt, lat);
    checkOutput("minud_rd", rd, 64'hFFFF_FFFF_8000_0000);
    checkOutput("minud_wdata", last_wdata64, 64'd1);
    checkOutput("minud_wsize", 64'(last_wsize64), 64'd1);

    // Operator sweep on word 0x400 (results chain through memory)
    poke(64'h400, 32'h0000_00F0);
    applyStimulus(1'b1, F_XOR, W3, 64'h400, 64'hFF, 6'h20, -1, '0, rd, err, rt, lat);
    checkOutput("xor_rd", rd, 64'hF0);
    checkOutput("xor_wr", {32'h0, last_wdata64[31:0]}, 64'h0F);
    applyStimulus(1'b1, F_MAX, W3, 64'h400, 64'hFFFF_FFFF, 6'h21, -1, '0, rd, err, rt, lat);
    checkOutput("max_rd", rd, 64'h0F);
    checkOutput("max_wr", {32'h0, last_wdata64[31:0]}, 64'h0F);
    applyStimulus(1'b1, F_MAXU, W3, 64'h400, 64'hFFFF_FFFF, 6'h22, -1, '0, rd, err, rt, lat);
    checkOutput("maxu_wr", {32'h0, last_wdata64[31:0]}, 64'hFFFF_FFFF);
    applyStimulus(1'b1, F_AND, W3, 64'h400, 64'hFF00, 6'h23, -1, '0, rd, err, rt, lat);
    checkOutput("and_rd_sext", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("and_wr", {32'h0, last_wdata64[31:0]}, 64'hFF00);
    applyStimulus(1'b1, F_OR, W3, 64'h400, 64'h1, 6'h24, -1, '0, rd, err, rt, lat);
    checkOutput("or_wr", {32'h0, last_wdata64[31:0]}, 64'hFF01);
    applyStimulus(1'b1, F_ADD, W3, 64'h400, 64'hFFFF_00FF, 6'h25, -1, '0, rd, err, rt, lat);
    checkOutput("addwrap_rd", rd, 64'hFF01);
    checkOutput("addwrap_wr", {32'h0, last_wdata64[31:0]}, 64'h0);
    applyStimulus(1'b1, F_MIN, W3, 64'h400, 64'h8000_0001, 6'h26, -1, '0, rd, err, rt, lat);
    checkOutput("mins_wr", {32'h0, last_wdata64[31:0]}, 64'h8000_0001);
    applyStimulus(1'b1, F_MINU, W3, 64'h400, 64'd5, 6'h27, -1, '0, rd, err, rt, lat);
    checkOutput("minu_rd", rd, 64'hFFFF_FFFF_8000_0001);
    checkOutput("minu_wr", {32'h0, last_wdata64[31:0]}, 64'd5);
    poke(64'h408, 32'h11);
    poke(64'h40C, 32'h22);
    applyStimulus(1'b1, F_SWAP, D3, 64'h408, 64'h1234_5678_9ABC_DEF0, 6'h28, -1, '0, rd, err, rt, lat);
    checkOutput("swapd_rd", rd, 64'h0000_0022_0000_0011);
    checkOutput("swapd_wr", last_wdata64, 64'h1234_5678_9ABC_DEF0);
    applyStimulus(1'b1, F_ADD, D3, 64'h408, 64'h10, 6'h29, -1, '0, rd, err, rt, lat);
    checkOutput("addd_rd", rd, 64'h1234_5678_9ABC_DEF0);
    checkOutput("addd_wr", last_wdata64, 64'h1234_5678_9ABC_DF00);

    // LR / SC pairing
    poke(64'h300, 32'hAAAA_5555);
    applyStimulus(1'b1, F_LR, W3, 64'h300, 64'd0, 6'h30, -1, '0, rd, err, rt, lat);
    checkOutput("lr_rd", rd, 64'hFFFF_FFFF_AAAA_5555);
    checkOutput("lr_lat", 64'(lat), 64'd3);
    wr0 = n_wr64;
    applyStimulus(1'b1, F_SC, W3, 64'h304, 64'd9, 6'h31, -1, '0, rd, err, rt, lat);
    checkOutput("sc_ok_rd", rd, 64'd0);
    checkOutput("sc_ok_lat", 64'(lat), 64'd2);
    checkOutput("sc_ok_writes", 64'(n_wr64 - wr0), 64'd1);
    checkOutput("sc_ok_waddr", last_waddr64, 64'h304);
    checkOutput("sc_ok_wdata", {32'h0, last_wdata64[31:0]}, 64'd9);
    rd0 = n_rd64; wr0 = n_wr64;
    applyStimulus(1'b1, F_SC, W3, 64'h300, 64'd9, 6'h32, -1, '0, rd, err, rt, lat);
    checkOutput("sc_again_rd", rd, 64'd1);
    checkOutput("sc_again_lat", 64'(lat), 64'd1);
    checkOutput("sc_again_nomem", 64'((n_rd64 - rd0) + (n_wr64 - wr0)), 64'd0);

    // Snoop during LR data wait, then snoop in the SC accept cycle
    applyStimulus(1'b1, F_LR, W3, 64'h300, 64'd0, 6'h33, 2, 64'h300, rd, err, rt, lat);
    wr0 = n_wr64;
    applyStimulus(1'b1, F_SC, W3, 64'h300, 64'd7, 6'h34, -1, '0, rd, err, rt, lat);
    checkOutput("sc_after_snoop_rd", rd, 64'd1);
    checkOutput("sc_after_snoop_nowr", 64'(n_wr64 - wr0), 64'd0);
    applyStimulus(1'b1, F_LR, W3, 64'h300, 64'd0, 6'h35, -1, '0, rd, err, rt, lat);
    applyStimulus(1'b1, F_SC, W3, 64'h300, 64'd7, 6'h36, 0, 64'h300, rd, err, rt, lat);
    checkOutput("sc_same_cyc_snoop_rd", rd, 64'd1);
    applyStimulus(1'b1, F_LR, W3, 64'h300, 64'd0, 6'h37, -1, '0, rd, err, rt, lat);
    applyStimulus(1'b1, F_SC, W3, 64'h300, 64'h77, 6'h38, 0, 64'h308, rd, err, rt, lat);
    checkOutput("sc_other_gran_snoop_rd", rd, 64'd0);
    checkOutput("sc_other_gran_wdata", {32'h0, last_wdata64[31:0]}, 64'h77);

    // Illegal and misaligned requests
    rd0 = n_rd64; wr0 = n_wr64;
    applyStimulus(1'b1, F_SWAP, W3, 64'h102, 64'd1, 6'h3A, -1, '0, rd, err, rt, lat);
    checkOutput("misal_err", 64'(err), 64'd1);
    checkOutput("misal_rd", rd, 64'd0);
    checkOutput("misal_tag", 64'(rt), 64'h3A);
    applyStimulus(1'b1, 5'b11111, W3, 64'h100, 64'd1, 6'h3B, -1, '0, rd, err, rt, lat);
    checkOutput("badop_err", 64'(err), 64'd1);
    checkOutput("badop_lat", 64'(lat), 64'd1);
    applyStimulus(1'b1, F_ADD, D3, 64'h204, 64'd1, 6'h3C, -1, '0, rd, err, rt, lat);
    checkOutput("misal_d_err", 64'(err), 64'd1);
    applyStimulus(1'b1, F_ADD, 3'b001, 64'h200, 64'd1, 6'h3D, -1, '0, rd, err, rt, lat);
    checkOutput("badw_err", 64'(err), 64'd1);
    checkOutput("err_nomem", 64'((n_rd64 - rd0) + (n_wr64 - wr0)), 64'd0);

    // Backpressure on the memory read and on the response
    poke(64'h500, 32'd3);
    mrdy64 = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    f5 = F_ADD; f3 = W3; addr = 64'h500; data = 64'd4; tag = 6'h2A; rv64 = 1'b1;
    @(negedge clk);
    rv64 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_rd_valid", 64'(m64_valid), 64'd1);
      checkOutput("bp_rd_we", 64'(m64_we), 64'd0);
      checkOutput("bp_rd_addr", m64_addr, 64'h500);
      @(negedge clk);
    end
    mrdy64 = 1'b1;
    w = 0;
    while (!r64_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 2; i++) begin
      checkOutput("bp_resp_valid", 64'(r64_valid), 64'd1);
      checkOutput("bp_resp_data", r64_data, 64'd3);
      checkOutput("bp_resp_tag", 64'(r64_tag), 64'h2A);
      @(negedge clk);
    end
    checkOutput("bp_wdata", {32'h0, last_wdata64[31:0]}, 64'd7);
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_released", 64'(r64_valid), 64'd0);
    checkOutput("bp_ready_again", 64'(r64_ready), 64'd1);

    // Reset while the write is pending aborts it
    poke(64'h600, 32'h10);
    @(negedge clk);
    f5 = F_SWAP; f3 = W3; addr = 64'h600; data = 64'h55; tag = 6'h15; rv64 = 1'b1;
    @(negedge clk);
    rv64 = 1'b0;
    w = 0;
    while (!(m64_valid && m64_we) && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("wr_reached", 64'(m64_we), 64'd1);
    wr0 = n_wr64;
    mrdy64 = 1'b0; reset = 1'b1;
    @(negedge clk);
    checkOutput("rstwr_mem_valid", 64'(m64_valid), 64'd0);
    checkOutput("rstwr_req_ready", 64'(r64_ready), 64'd1);
    checkOutput("rstwr_resp_valid", 64'(r64_valid), 64'd0);
    checkOutput("rstwr_resp_tag", 64'(r64_tag), 64'd0);
    reset = 1'b0; mrdy64 = 1'b1;
    applyStimulus(1'b1, F_ADD, W3, 64'h600, 64'd1, 6'h16, -1, '0, rd, err, rt, lat);
    checkOutput("rstwr_no_write", 64'(n_wr64 - wr0), 64'd1);
    checkOutput("rstwr_old_kept", rd, 64'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
